// File: rtl/lab2_proc_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : lab2_proc_mem_responder
// Description : Single-port word-organised test memory answering mem_req_4B_t
//               requests with mem_resp_4B_t responses after p_latency extra
//               cycles. Optional request counters are enabled by defining
//               LAB2_PROC_MEM_RESPONDER_STATS_EN (adds num_reads/num_writes).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lab2_proc_mem_responder #(
  parameter int p_mem_nwords = 256,
  parameter int p_latency    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqstream_val,
  output logic        reqstream_rdy,
  input  logic [76:0] reqstream_msg,
  output logic        respstream_val,
  input  logic        respstream_rdy,
  output logic [46:0] respstream_msg
`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0] num_reads,
  output logic [31:0] num_writes
`endif
);

  localparam int         c_aw       = $clog2(p_mem_nwords);
  localparam logic [3:0] c_lat_load = (p_latency > 0) ? 4'(p_latency - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // A freshly accepted request skips DELAY entirely when there is no latency.
  localparam state_t c_first_state = (p_latency > 0) ? ST_DELAY : ST_RESP;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_count;
  logic [3:0]        w_count_next;
  logic [46:0]       r_resp_msg;
  logic [31:0]       r_mem [p_mem_nwords];

  logic [2:0]        w_type;
  logic [7:0]        w_opaque;
  logic [1:0]        w_off;
  logic [1:0]        w_len;
  logic [31:0]       w_data;
  logic [c_aw-1:0]   w_idx;
  logic              w_is_wr;
  logic              w_req_fire;
  logic [4:0]        w_shamt;
  logic [31:0]       w_len_mask;
  logic [31:0]       w_wr_mask;
  logic [31:0]       w_cur_word;
  logic [31:0]       w_merge_word;
  logic [31:0]       w_rd_data;
  logic              w_unused_addr;

  assign w_type   = reqstream_msg[76:74];
  assign w_opaque = reqstream_msg[73:66];
  assign w_idx    = reqstream_msg[36 +: c_aw];
  assign w_off    = reqstream_msg[35:34];
  assign w_len    = reqstream_msg[33:32];
  assign w_data   = reqstream_msg[31:0];

  // Upper address bits fall outside the array; addresses wrap modulo its size.
  assign w_unused_addr = ^reqstream_msg[65:36+c_aw];

  // Types 3..7 are unknown and behave as reads.
  assign w_is_wr    = (w_type == 3'd1) || (w_type == 3'd2);
  assign w_req_fire = reqstream_val && reqstream_rdy;
  assign w_shamt    = {w_off, 3'b000};
  assign w_cur_word = r_mem[w_idx];

  // Byte lane mask for the access length; len=0 means a full word.
  always_comb begin
    w_len_mask = 32'hffff_ffff;
    case (w_len)
      2'd1:    w_len_mask = 32'h0000_00ff;
      2'd2:    w_len_mask = 32'h0000_ffff;
      2'd3:    w_len_mask = 32'h00ff_ffff;
      default: w_len_mask = 32'hffff_ffff;
    endcase
  end

  // Shifting by the byte offset naturally drops lanes past the word boundary.
  assign w_wr_mask    = w_len_mask << w_shamt;
  assign w_merge_word = (w_cur_word & ~w_wr_mask) | ((w_data << w_shamt) & w_wr_mask);
  assign w_rd_data    = (w_cur_word >> w_shamt) & w_len_mask;

  // Memory array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (reset && w_req_fire && w_is_wr) begin
      r_mem[w_idx] <= w_merge_word;
    end
  end

  // State and delay counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Next-state, handshake outputs and delay counter control.
  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    reqstream_rdy  = 1'b0;
    respstream_val = 1'b0;
    case (r_state)
      ST_IDLE: begin
        reqstream_rdy = 1'b1;
        if (reqstream_val) begin
          w_state_next = c_first_state;
          w_count_next = c_lat_load;
        end
      end
      ST_DELAY: begin
        if (r_count == 4'd0) begin
          w_state_next = ST_RESP;
        end else begin
          w_count_next = r_count - 4'd1;
        end
      end
      ST_RESP: begin
        respstream_val = 1'b1;
        reqstream_rdy  = respstream_rdy;
        if (respstream_rdy) begin
          if (reqstream_val) begin
            w_state_next = c_first_state;
            w_count_next = c_lat_load;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Response is captured at accept time and held until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_msg <= 47'd0;
    end else if (w_req_fire) begin
      r_resp_msg <= {w_type, w_opaque, 2'b00, w_len, (w_is_wr ? 32'h0 : w_rd_data)};
    end
  end

  assign respstream_msg = r_resp_msg;

`ifdef LAB2_PROC_MEM_RESPONDER_STATS_EN
  logic [31:0] r_num_reads;
  logic [31:0] r_num_writes;

  // Free-running request counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_num_reads  <= 32'd0;
      r_num_writes <= 32'd0;
    end else if (w_req_fire) begin
      if (w_is_wr) begin
        r_num_writes <= r_num_writes + 32'd1;
      end else begin
        r_num_reads <= r_num_reads + 32'd1;
      end
    end
  end

  assign num_reads  = r_num_reads;
  assign num_writes = r_num_writes;
`endif

endmodule

`default_nettype wire
